gpio_reg_ctrl: RTL and testbench

GPIO_REG_CTRL -- requirements
Module: gpio_reg_ctrl

---
 rtl/gpio_reg_ctrl.sv | 156 +++++++++++++++
 tb/tb_gpio_reg_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_reg_ctrl.sv
// gpio_reg_ctrl: decodes GPIO-strobed CPU commands into byte-assembled writes and
// pointer-based reads of two 16-bit sample memories (A and C).
module gpio_reg_ctrl #(
  parameter int          ADDR_W      = 4,
  parameter logic [15:0] A_WR_REG    = 16'd1,
  parameter logic [15:0] A_RD_REG    = 16'd2,
  parameter logic [15:0] C_WR_REG    = 16'd3,
  parameter logic [15:0] C_RD_REG    = 16'd4,
  parameter logic [15:0] PTR_RST_REG = 16'd5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out_bus,
  output logic              a_wr_en,
  output logic [ADDR_W-1:0] a_wr_addr,
  output logic [15:0]       a_wr_data,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [15:0]       a_rd_data,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic [15:0]       c_wr_data,
  output logic              c_rd_en,
  output logic [ADDR_W-1:0] c_rd_addr,
  input  logic [15:0]       c_rd_data
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAPTURE} state_t;
  state_t                   state_q, state_d;
  logic [24:0]              sync1_q, sync2_q;
  logic [1:0]               vld_q;
  logic                     prev_q;
  logic                     rise, cmd, tgt, is_wr, is_rd, is_prst, unused_bits;
  logic [15:0]              addr;
  logic [7:0]               data;
  logic                     tgt_q, tgt_d, err_q, err_d;
  logic [1:0]               phase_q, phase_d;
  logic [1:0][7:0]          hi_q, hi_d;
  logic [7:0]               lo_q, lo_d;
  logic [1:0][ADDR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0]              rdata_q, rdata_d;

  assign unused_bits = ^gpio_in[31:25];
  assign addr    = sync2_q[23:8];
  assign data    = sync2_q[7:0];
  // prev_q is held high until the synchronizer carries real samples, so a
  // strobe already high at reset release never looks like a fresh edge
  assign rise    = vld_q[1] & sync2_q[24] & ~prev_q;
  assign cmd     = rise && state_q == IDLE;
  assign tgt     = addr == C_WR_REG || addr == C_RD_REG;
  assign is_wr   = addr == A_WR_REG || addr == C_WR_REG;
  assign is_rd   = addr == A_RD_REG || addr == C_RD_REG;
  assign is_prst = addr == PTR_RST_REG;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= gpio_in[24:0];
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      prev_q  <= ~vld_q[1] | sync2_q[24];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:              state_d = !cmd ? IDLE : is_rd ? RD_ISSUE : (is_wr && phase_q[tgt]) ? WRITE : IDLE;
      RD_ISSUE:          state_d = RD_WAIT;
      RD_WAIT:           state_d = RD_CAPTURE;
      WRITE, RD_CAPTURE: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_d   = tgt_q;
    err_d   = err_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (rise && state_q != IDLE) err_d = 1'b1;
    if (cmd) begin
      if (is_wr) begin
        tgt_d = tgt;
        if (!phase_q[tgt]) begin
          hi_d[tgt]    = data;
          phase_d[tgt] = 1'b1;
        end else lo_d = data;
      end else if (is_rd) tgt_d = tgt;
      else if (is_prst) begin
        wptr_d  = '0;
        rptr_d  = '0;
        phase_d = '0;
        err_d   = 1'b0;
      end else err_d = 1'b1;
    end
    if (state_q == WRITE) begin
      wptr_d[tgt_q]  = wptr_q[tgt_q] + ADDR_W'(1);
      phase_d[tgt_q] = 1'b0;
    end
    if (state_q == RD_CAPTURE) begin
      rdata_d        = tgt_q ? c_rd_data : a_rd_data;
      rptr_d[tgt_q]  = rptr_q[tgt_q] + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q   <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  // busy covers the accepting cycle too, so a read shows busy for four cycles
  always_comb begin
    a_wr_en      = state_q == WRITE && !tgt_q;
    c_wr_en      = state_q == WRITE && tgt_q;
    a_rd_en      = state_q == RD_ISSUE && !tgt_q;
    c_rd_en      = state_q == RD_ISSUE && tgt_q;
    a_wr_addr    = a_wr_en ? wptr_q[0] : '0;
    c_wr_addr    = c_wr_en ? wptr_q[1] : '0;
    a_wr_data    = a_wr_en ? {hi_q[0], lo_q} : '0;
    c_wr_data    = c_wr_en ? {hi_q[1], lo_q} : '0;
    a_rd_addr    = a_rd_en ? rptr_q[0] : '0;
    c_rd_addr    = c_rd_en ? rptr_q[1] : '0;
    gpio_out_bus = {state_q != IDLE || cmd, err_q, 14'b0, rdata_q};
  end
endmodule

// File: tb/tb_gpio_reg_ctrl.sv
// tb_gpio_reg_ctrl: directed and random GPIO command traffic against a
// queue/array-level model of the command protocol and the two memories.
module tb_gpio_reg_ctrl;
  localparam int AW = 4, DEPTH = 16;
  localparam logic [15:0] A_WR = 16'd1, A_RD = 16'd2, C_WR = 16'd3, C_RD = 16'd4, PRST = 16'd5;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] gpio_in = '0, gpio_out_bus;
  logic a_wr_en, a_rd_en, c_wr_en, c_rd_en;
  logic [AW-1:0] a_wr_addr, a_rd_addr, c_wr_addr, c_rd_addr;
  logic [15:0] a_wr_data, c_wr_data;
  logic [15:0] a_rd_data = '0, c_rd_data = '0;
  logic [15:0] amem [DEPTH] = '{default: '0};
  logic [15:0] cmem [DEPTH] = '{default: '0};

  always #5 clk = ~clk;

  gpio_reg_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out_bus(gpio_out_bus),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data)
  );

  always @(posedge clk) begin
    if (a_wr_en) amem[a_wr_addr] <= a_wr_data;
    if (c_wr_en) cmem[c_wr_addr] <= c_wr_data;
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    if (c_rd_en) c_rd_data <= cmem[c_rd_addr];
  end

  int a_wc = 0, c_wc = 0, a_rc = 0, c_rc = 0, busy_n = 0, clash = 0;
  logic [20:0] wlast = '0;
  always @(negedge clk) begin
    if (a_wr_en) begin a_wc <= a_wc + 1; wlast <= {1'b0, a_wr_addr, a_wr_data}; end
    if (c_wr_en) begin c_wc <= c_wc + 1; wlast <= {1'b1, c_wr_addr, c_wr_data}; end
    if (a_rd_en) a_rc <= a_rc + 1;
    if (c_rd_en) c_rc <= c_rc + 1;
    if (gpio_out_bus[31]) busy_n <= busy_n + 1;
    if (((a_wr_en | a_rd_en) & (c_wr_en | c_rd_en)) | (a_wr_en & a_rd_en) | (c_wr_en & c_rd_en))
      clash <= clash + 1;
  end

  // reference model: plain pointer arithmetic over arrays
  int wp[2], rp[2], ewc[2], erc[2];
  bit ph[2];
  bit m_err;
  logic [7:0] hi[2];
  logic [15:0] m_rd;
  logic [15:0] rmem[2][DEPTH];
  logic [20:0] ewlast;
  int n_vec = 0, n_err = 0;

  function automatic void m_cmd(input logic [15:0] a, input logic [7:0] d);
    int t;
    t = (a == C_WR || a == C_RD) ? 1 : 0;
    if (a == A_WR || a == C_WR) begin
      if (!ph[t]) begin hi[t] = d; ph[t] = 1'b1; end
      else begin
        rmem[t][wp[t]] = {hi[t], d};
        ewc[t]++;
        ewlast = {t[0], 4'(wp[t]), hi[t], d};
        wp[t] = (wp[t] + 1) % DEPTH;
        ph[t] = 1'b0;
      end
    end else if (a == A_RD || a == C_RD) begin
      m_rd = rmem[t][rp[t]];
      erc[t]++;
      rp[t] = (rp[t] + 1) % DEPTH;
    end else if (a == PRST) begin
      wp = '{0, 0}; rp = '{0, 0}; ph = '{0, 0}; m_err = 1'b0;
    end else m_err = 1'b1;
  endfunction

  function automatic void m_reset();
    wp = '{0, 0}; rp = '{0, 0}; ph = '{0, 0}; m_err = 1'b0; m_rd = '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":bus"}, gpio_out_bus, {1'b0, m_err, 14'b0, m_rd});
    chk({tag, ":cnt"}, {8'(a_wc), 8'(c_wc), 8'(a_rc), 8'(c_rc)},
        {8'(ewc[0]), 8'(ewc[1]), 8'(erc[0]), 8'(erc[1])});
    chk({tag, ":wr"}, 32'(wlast), 32'(ewlast));
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    gpio_in = {7'($urandom), 1'b1, a, d};
    repeat (hold) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_cmd(input string tag, input logic [15:0] a, input logic [7:0] d, input int hold);
    send(a, d, hold);
    m_cmd(a, d);
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ":bus"}, gpio_out_bus, 32'h0);
    chk({tag, ":ports"}, 32'(|{a_wr_en, a_rd_en, c_wr_en, c_rd_en, a_wr_addr, a_rd_addr,
                               c_wr_addr, c_rd_addr, a_wr_data, c_wr_data}), 32'h0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [15:0] oa;
    int b0, k;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < DEPTH; i++) rmem[t][i] = '0;
      ewc[t] = 0; erc[t] = 0; hi[t] = '0;
    end
    ewlast = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_cmd("a_hi", A_WR, 8'h00, 3);
      do_cmd("a_lo", A_WR, 8'(i), 3);
    end
    for (int i = 0; i < 16; i++) begin
      do_cmd("a_rd", A_RD, 8'($urandom), 3);
      chk("a_rd_seq", 32'(gpio_out_bus[15:0]), 32'(i));
    end
    for (int i = 0; i < 16; i++) begin
      do_cmd("c_hi", C_WR, 8'h00, 2);
      do_cmd("c_lo", C_WR, 8'(i), 2);
    end
    for (int i = 0; i < 16; i++) begin
      do_cmd("c_rd", C_RD, 8'hFF, 2);
      chk("c_rd_seq", 32'(gpio_out_bus[15:0]), 32'(i));
    end
    do_cmd("a_wrapped", A_RD, 8'h00, 3);
    chk("a_wrap_val", 32'(gpio_out_bus[15:0]), 32'h0);

    do_cmd("prst0", PRST, 8'h00, 2);
    for (int i = 0; i < 16; i++) begin
      do_cmd("w17_hi", A_WR, 8'($urandom), 1);
      do_cmd("w17_lo", A_WR, 8'($urandom), 1);
    end
    do_cmd("w17_hi", A_WR, 8'hBE, 2);
    do_cmd("w17_lo", A_WR, 8'hEF, 2);
    chk("w17_addr", 32'(wlast), {11'b0, 1'b0, 4'd0, 16'hBEEF});
    do_cmd("prst1", PRST, 8'h00, 2);
    do_cmd("beef_rd", A_RD, 8'h00, 2);
    chk("beef_val", 32'(gpio_out_bus[15:0]), 32'hBEEF);

    do_cmd("half", A_WR, 8'h12, 2);
    pulse_reset("rst_half");
    do_cmd("after_hi", A_WR, 8'h00, 2);
    do_cmd("after_lo", A_WR, 8'h34, 2);
    chk("half_drop", 32'(wlast), {11'b0, 1'b0, 4'd0, 16'h0034});

    do_cmd("bad_addr", 16'h0077, 8'h5A, 2);
    chk("bad_err", 32'(gpio_out_bus[30]), 32'h1);
    @(negedge clk);
    gpio_in = {7'h0, 1'b1, A_RD, 8'h00};
    @(negedge clk) gpio_in[24] = 1'b0;
    @(negedge clk) gpio_in[24] = 1'b1;
    @(negedge clk) gpio_in[24] = 1'b0;
    repeat (8) @(negedge clk);
    m_cmd(A_RD, 8'h00);
    m_err = 1'b1;
    check_all("busy_edge");
    do_cmd("prst_err", PRST, 8'h00, 2);
    chk("err_clr", 32'(gpio_out_bus[30]), 32'h0);

    @(negedge clk);
    gpio_in = {7'h0, 1'b1, A_RD, 8'h00};
    repeat (4) @(negedge clk);
    rst = 1'b0;
    erc[0]++;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_rdwait");
    rst = 1'b1;
    m_reset();
    repeat (10) @(negedge clk);
    check_all("held_wclk");
    gpio_in[24] = 1'b0;
    repeat (4) @(negedge clk);
    do_cmd("post_rst_rd", A_RD, 8'h00, 2);

    b0 = busy_n;
    do_cmd("hold20", A_RD, 8'h00, 20);
    chk("busy_len", 32'(busy_n - b0), 32'd4);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      oa = 16'($urandom);
      while (oa >= 16'd1 && oa <= 16'd5) oa = 16'($urandom);
      oa = k < 3 ? A_WR : k < 6 ? C_WR : k == 6 ? A_RD : k == 7 ? C_RD : k == 8 ? PRST : oa;
      do_cmd("rand", oa, 8'($urandom), $urandom_range(1, 4));
    end

    chk("port_clash", 32'(clash), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
